// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: buffered UART transmitter.
// Bytes written with write_uart are queued in a small FIFO. A framing FSM
// pops one byte at a time and shifts it out LSB first on tx as 8N1, or as
// 8E1 when UART_TX_PARITY_EN is defined.
// The module has its own baud divider. dbg_state_o exposes the FSM state.
// Optional feature macro: UART_TX_PARITY_EN (adds an even-parity bit).
module uart_tx_fifo #(
    parameter int DBITS    = 8,
    parameter int SB_TICK  = 16,
    parameter int BAUD_DIV = 651,
    parameter int FIFO_AW  = 2
) (
    input  logic             clk_100MHz,
    input  logic             reset,
    input  logic             write_uart,
    input  logic [DBITS-1:0] write_data,
    output logic             tx_full,
    output logic             tx_empty,
    output logic             tx_busy,
    output logic             tx,
    output logic [2:0]       dbg_state_o
);

    localparam int DEPTH  = 1 << FIFO_AW;
    localparam int DIV_W  = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int TICK_W = (SB_TICK > 1) ? $clog2(SB_TICK) : 1;
    localparam int BIT_W  = (DBITS > 1) ? $clog2(DBITS) : 1;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // FIFO storage and bookkeeping
    logic [DBITS-1:0]   mem_q [DEPTH];
    logic [FIFO_AW-1:0] wptr_q, rptr_q;
    logic [FIFO_AW:0]   count_q;
    logic               fifo_empty, fifo_full;
    logic               push, pop;
    logic [DBITS-1:0]   head;

    // Framing FSM state
    state_t             state_q;
    logic [DIV_W-1:0]   div_q;
    logic [TICK_W-1:0]  s_q;
    logic [BIT_W-1:0]   n_q;
    logic [DBITS-1:0]   shift_q;
    logic               par_q;
    logic               tx_q;
    logic               busy_q;
    logic               tick;
    logic               last_tick;

    assign fifo_empty = (count_q == '0);
    assign fifo_full  = (count_q == (FIFO_AW+1)'(DEPTH));
    assign head       = mem_q[rptr_q];

    // The FSM pops only from IDLE. A write on a full FIFO is taken only when a
    // pop frees a slot in the same cycle.
    assign pop  = (state_q == S_IDLE) && !fifo_empty;
    assign push = write_uart && (!fifo_full || pop);

    // The divider runs only while a frame is in progress, so every bit is full length.
    assign tick      = (state_q != S_IDLE) && (div_q == DIV_W'(BAUD_DIV - 1));
    assign last_tick = tick && (s_q == TICK_W'(SB_TICK - 1));

    // Storage write. There is no reset: stale entries are unreachable once the pointers clear.
    always_ff @(posedge clk_100MHz) begin
        if (reset && push) begin
            mem_q[wptr_q] <= write_data;
        end
    end

    // FIFO pointers and occupancy count
    always_ff @(posedge clk_100MHz) begin
        if (!reset) begin
            wptr_q  <= '0;
            rptr_q  <= '0;
            count_q <= '0;
        end else begin
            if (push) wptr_q <= wptr_q + FIFO_AW'(1);
            if (pop)  rptr_q <= rptr_q + FIFO_AW'(1);
            case ({push, pop})
                2'b10:   count_q <= count_q + (FIFO_AW+1)'(1);
                2'b01:   count_q <= count_q - (FIFO_AW+1)'(1);
                default: count_q <= count_q;
            endcase
        end
    end

    // Framing FSM with baud divider and registered tx/busy outputs
    always_ff @(posedge clk_100MHz) begin
        if (!reset) begin
            state_q <= S_IDLE;
            div_q   <= '0;
            s_q     <= '0;
            n_q     <= '0;
            shift_q <= '0;
            par_q   <= 1'b0;
            tx_q    <= 1'b1;
            busy_q  <= 1'b0;
        end else begin
            // The line shows the state that was current before this edge.
            case (state_q)
                S_START:  tx_q <= 1'b0;
                S_DATA:   tx_q <= shift_q[0];
                S_PARITY: tx_q <= par_q;
                default:  tx_q <= 1'b1;
            endcase
            busy_q <= (state_q != S_IDLE);

            if (state_q == S_IDLE || tick) begin
                div_q <= '0;
            end else begin
                div_q <= div_q + DIV_W'(1);
            end

            if (tick) begin
                s_q <= last_tick ? '0 : s_q + TICK_W'(1);
            end

            case (state_q)
                S_IDLE: begin
                    if (pop) begin
                        shift_q <= head;
                        par_q   <= ^head;
                        s_q     <= '0;
                        n_q     <= '0;
                        state_q <= S_START;
                    end
                end
                S_START: begin
                    if (last_tick) state_q <= S_DATA;
                end
                S_DATA: begin
                    if (last_tick) begin
                        shift_q <= shift_q >> 1;
                        if (n_q == BIT_W'(DBITS - 1)) begin
                            n_q <= '0;
`ifdef UART_TX_PARITY_EN
                            state_q <= S_PARITY;
`else
                            state_q <= S_STOP;
`endif
                        end else begin
                            n_q <= n_q + BIT_W'(1);
                        end
                    end
                end
                S_PARITY: begin
                    if (last_tick) state_q <= S_STOP;
                end
                S_STOP: begin
                    if (last_tick) state_q <= S_IDLE;
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

    assign tx          = tx_q;
    assign tx_busy     = busy_q;
    assign tx_full     = fifo_full;
    assign tx_empty    = fifo_empty;
    assign dbg_state_o = state_q;

endmodule
